// File: rtl/matvec_pkg.sv
// Shared types and constants for the matrix-vector multiplier: FSM state
// encoding and the signed saturation bounds of an ACCW-bit accumulator.
package matvec_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W  = 3'd1,
    LOAD_X  = 3'd2,
    COMPUTE = 3'd3,
    OUT     = 3'd4
  } state_t;

  // Bounds are returned MAX_ACCW+1 bits wide; callers keep the low ACCW+1 bits.
  localparam int MAX_ACCW = 64;

  function automatic logic [MAX_ACCW:0] sat_max_f(input int accw);
    logic [MAX_ACCW:0] one;
    one = 1;
    return (one << (accw - 1)) - one;
  endfunction

  function automatic logic [MAX_ACCW:0] sat_min_f(input int accw);
    return ~sat_max_f(accw);
  endfunction

endpackage

// File: rtl/matvec_param_memory.sv
// Simple dual-port storage: one write port, one read port with a registered
// (1-cycle latency) read data output. Contents are not reset.
module matvec_param_memory #(
  parameter int  WIDTH = 14,
  parameter int  SIZE  = 9,
  localparam int AW    = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [SIZE];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/matvec_param.sv
// Streaming y = W*X engine: loads an NxN matrix (optional, reused across jobs)
// and an N-vector, then emits one saturated row result per output handshake.
// Legal configurations: 2 <= N <= 8, 2*DW <= ACCW <= 64.
module matvec_param
  import matvec_pkg::*;
#(
  parameter int N    = 3,
  parameter int DW   = 14,
  parameter int ACCW = 2 * DW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            input_valid,
  output logic            input_ready,
  input  logic [DW-1:0]   input_data,
  input  logic            new_matrix,
  output logic            output_valid,
  input  logic            output_ready,
  output logic [ACCW-1:0] output_data,
  output logic            output_last,
  output logic            output_sat,
  output state_t          dbg_state
);

  localparam int NN  = N * N;
  localparam int WAW = $clog2(NN);
  localparam int XAW = $clog2(N);
  localparam int CW  = $clog2(N + 1);

  localparam logic [WAW-1:0] W_LAST = WAW'(NN - 1);
  localparam logic [XAW-1:0] X_LAST = XAW'(N - 1);
  localparam logic [CW-1:0]  C_LAST = CW'(N);

  localparam logic [MAX_ACCW:0]   SMAX_FULL = sat_max_f(ACCW);
  localparam logic [MAX_ACCW:0]   SMIN_FULL = sat_min_f(ACCW);
  localparam logic signed [ACCW:0] SAT_MAX  = $signed(SMAX_FULL[ACCW:0]);
  localparam logic signed [ACCW:0] SAT_MIN  = $signed(SMIN_FULL[ACCW:0]);

  state_t                 state_q, state_d;
  logic [WAW-1:0]         w_cnt_q, w_cnt_d;
  logic [XAW-1:0]         x_cnt_q, x_cnt_d;
  logic [XAW-1:0]         row_q, row_d;
  logic [CW-1:0]          cyc_q, cyc_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic                   sat_q, sat_d;
  logic                   stored_q, stored_d;
  logic                   rdy_en_q;

  logic                   xfer;
  logic                   w_we, x_we;
  logic [WAW-1:0]         w_waddr, w_raddr;
  logic [XAW-1:0]         x_waddr, x_raddr;
  logic [DW-1:0]          w_rd, x_rd;

  logic [2*DW-1:0]        w_ext, x_ext, prod;
  logic signed [ACCW:0]   prod_ext, sum_full;
  logic [ACCW-1:0]        sum_sat;
  logic                   sum_clamp;

  // Handshake: a word moves on input_valid && input_ready, a result moves on
  // output_valid && output_ready; producers never wait on the other side's
  // ready before asserting valid.
  assign xfer         = input_valid && input_ready;
  assign input_ready  = rdy_en_q &&
                        ((state_q == IDLE) || (state_q == LOAD_W) || (state_q == LOAD_X));
  assign output_valid = (state_q == OUT);
  assign output_data  = acc_q;
  assign output_last  = output_valid && (row_q == X_LAST);
  assign output_sat   = output_valid && sat_q;
  assign dbg_state    = state_q;

  matvec_param_memory #(.WIDTH(DW), .SIZE(NN)) u_w_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (input_data),
    .raddr (w_raddr),
    .rdata (w_rd)
  );

  matvec_param_memory #(.WIDTH(DW), .SIZE(N)) u_x_mem (
    .clk   (clk),
    .we    (x_we),
    .waddr (x_waddr),
    .wdata (input_data),
    .raddr (x_raddr),
    .rdata (x_rd)
  );

  // Full-precision MAC: the ACCW+1 bit sum cannot overflow before clamping.
  always_comb begin
    w_ext     = {{DW{w_rd[DW-1]}}, w_rd};
    x_ext     = {{DW{x_rd[DW-1]}}, x_rd};
    prod      = w_ext * x_ext;
    prod_ext  = {{(ACCW + 1 - 2 * DW){prod[2*DW-1]}}, prod};
    sum_full  = {acc_q[ACCW-1], acc_q} + prod_ext;
    sum_clamp = 1'b0;
    sum_sat   = sum_full[ACCW-1:0];
    if (sum_full > SAT_MAX) begin
      sum_sat   = SAT_MAX[ACCW-1:0];
      sum_clamp = 1'b1;
    end else if (sum_full < SAT_MIN) begin
      sum_sat   = SAT_MIN[ACCW-1:0];
      sum_clamp = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    w_cnt_d  = w_cnt_q;
    x_cnt_d  = x_cnt_q;
    row_d    = row_q;
    cyc_d    = cyc_q;
    acc_d    = acc_q;
    sat_d    = sat_q;
    stored_d = stored_q;
    w_we     = 1'b0;
    x_we     = 1'b0;
    w_waddr  = w_cnt_q;
    x_waddr  = x_cnt_q;
    w_raddr  = '0;
    x_raddr  = '0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (new_matrix || !stored_q) begin
            w_we    = 1'b1;
            w_waddr = '0;
            w_cnt_d = WAW'(1);
            state_d = LOAD_W;
          end else begin
            x_we    = 1'b1;
            x_waddr = '0;
            x_cnt_d = XAW'(1);
            state_d = LOAD_X;
          end
        end
      end

      LOAD_W: begin
        if (xfer) begin
          w_we = 1'b1;
          if (w_cnt_q == W_LAST) begin
            w_cnt_d  = '0;
            stored_d = 1'b1;
            state_d  = LOAD_X;
          end else begin
            w_cnt_d = w_cnt_q + WAW'(1);
          end
        end
      end

      LOAD_X: begin
        if (xfer) begin
          x_we = 1'b1;
          if (x_cnt_q == X_LAST) begin
            x_cnt_d = '0;
            row_d   = '0;
            cyc_d   = '0;
            acc_d   = '0;
            sat_d   = 1'b0;
            state_d = COMPUTE;
          end else begin
            x_cnt_d = x_cnt_q + XAW'(1);
          end
        end
      end

      COMPUTE: begin
        // Reads issue on cycles 0..N-1; data lands one cycle later.
        if (cyc_q != C_LAST) begin
          w_raddr = WAW'(int'(row_q) * N + int'(cyc_q));
          x_raddr = XAW'(cyc_q);
        end
        if (cyc_q != '0) begin
          acc_d = sum_sat;
          sat_d = sat_q | sum_clamp;
        end
        if (cyc_q == C_LAST) begin
          cyc_d   = '0;
          state_d = OUT;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      OUT: begin
        if (output_ready) begin
          if (row_q == X_LAST) begin
            row_d   = '0;
            state_d = IDLE;
          end else begin
            row_d   = row_q + XAW'(1);
            cyc_d   = '0;
            acc_d   = '0;
            sat_d   = 1'b0;
            state_d = COMPUTE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      w_cnt_q  <= '0;
      x_cnt_q  <= '0;
      row_q    <= '0;
      cyc_q    <= '0;
      acc_q    <= '0;
      sat_q    <= 1'b0;
      stored_q <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_cnt_q  <= w_cnt_d;
      x_cnt_q  <= x_cnt_d;
      row_q    <= row_d;
      cyc_q    <= cyc_d;
      acc_q    <= acc_d;
      sat_q    <= sat_d;
      stored_q <= stored_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule
